// File: rtl/boxcar_mc_if.sv
// boxcar_mc_if: valid/ready stream carrying a channel index and a data word
interface boxcar_mc_if #(
   parameter int CW = 2,
   parameter int DW = 16
) ();
   logic          valid;
   logic          ready;
   logic [CW-1:0] chan;
   logic [DW-1:0] data;
   modport master (output valid, chan, data, input ready);
   modport slave  (input valid, chan, data, output ready);
endinterface

// File: rtl/boxcar_mc.sv
// boxcar_mc: multi-channel moving-window sum, two-cycle latency; define BOXCAR_MC_PRIME_EN to suppress results until a channel is primed
module boxcar_mc #(
   parameter int IW    = 16,
   parameter int LGMEM = 6,
   parameter int LGCH  = 2,
   parameter int OW    = IW + LGMEM
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_clear,
   input  logic [LGMEM-1:0]       i_navg,
   boxcar_mc_if.slave             s,
   boxcar_mc_if.master            m,
   output logic [(1<<LGCH)-1:0]   o_primed
);
   localparam int NCH   = 1 << LGCH;
   localparam int DEPTH = 1 << LGMEM;
   logic [IW-1:0]    hist [NCH*DEPTH];
   logic [OW-1:0]    sum_q [NCH], sum_d [NCH];
   logic [LGMEM-1:0] wp_q [NCH], wp_d [NCH];
   logic [LGMEM-1:0] fill_q [NCH], fill_d [NCH];
   logic [NCH-1:0]   primed_q, primed_d;
   logic             p1_valid_q, p1_valid_d;
   logic [LGCH-1:0]  p1_chan_q, p1_chan_d;
   logic [IW-1:0]    p1_data_q, p1_data_d;
   logic             m_valid_q, m_valid_d;
   logic [LGCH-1:0]  m_chan_q, m_chan_d;
   logic [OW-1:0]    m_data_q, m_data_d;
   logic             rdy_q;
   logic             stall, accept, prime_new, emit;
   logic [LGMEM-1:0] n, rd_ptr, fill_new;
   logic [IW-1:0]    old;
   logic [OW-1:0]    sum_new;
   assign stall    = m_valid_q && !m.ready;
   assign s.ready  = rdy_q && !stall && !i_clear;
   assign accept   = s.valid && s.ready;
   assign m.valid  = m_valid_q;
   assign m.chan   = m_chan_q;
   assign m.data   = m_data_q;
   assign o_primed = primed_q;
   // stage-1 arithmetic: drop the sample leaving the window once the channel holds N samples
   always_comb begin
      n         = (i_navg == '0) ? LGMEM'(1) : i_navg;
      rd_ptr    = wp_q[p1_chan_q] - n;
      old       = (fill_q[p1_chan_q] >= n) ? hist[{p1_chan_q, rd_ptr}] : '0;
      sum_new   = sum_q[p1_chan_q] + OW'(p1_data_q) - OW'(old);
      fill_new  = (fill_q[p1_chan_q] == '1) ? fill_q[p1_chan_q] : fill_q[p1_chan_q] + LGMEM'(1);
      prime_new = fill_new >= n;
`ifdef BOXCAR_MC_PRIME_EN
      emit      = p1_valid_q && prime_new;
`else
      emit      = p1_valid_q;
`endif
   end
   // next state: clear flushes everything, a stall freezes everything, otherwise advance one stage
   always_comb begin
      sum_d      = sum_q;
      wp_d       = wp_q;
      fill_d     = fill_q;
      primed_d   = primed_q;
      p1_valid_d = p1_valid_q;
      p1_chan_d  = p1_chan_q;
      p1_data_d  = p1_data_q;
      m_valid_d  = m_valid_q;
      m_chan_d   = m_chan_q;
      m_data_d   = m_data_q;
      if (i_clear) begin
         for (int c = 0; c < NCH; c++) begin
            sum_d[c]  = '0;
            wp_d[c]   = '0;
            fill_d[c] = '0;
         end
         primed_d   = '0;
         p1_valid_d = 1'b0;
         m_valid_d  = 1'b0;
      end else if (!stall) begin
         p1_valid_d = accept;
         p1_chan_d  = accept ? s.chan : p1_chan_q;
         p1_data_d  = accept ? s.data : p1_data_q;
         m_valid_d  = emit;
         m_chan_d   = emit ? p1_chan_q : m_chan_q;
         m_data_d   = emit ? sum_new : m_data_q;
         if (p1_valid_q) begin
            sum_d[p1_chan_q]    = sum_new;
            wp_d[p1_chan_q]     = wp_q[p1_chan_q] + LGMEM'(1);
            fill_d[p1_chan_q]   = fill_new;
            primed_d[p1_chan_q] = prime_new;
         end
      end
   end
   // sample history, written as the beat leaves stage 1; contents never need a reset
   always_ff @(posedge i_clk) begin
      if (p1_valid_q && !stall && !i_clear)
         hist[{p1_chan_q, wp_q[p1_chan_q]}] <= p1_data_q;
   end
   // state registers with asynchronous flush
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sum_q      <= '{default: '0};
         wp_q       <= '{default: '0};
         fill_q     <= '{default: '0};
         primed_q   <= '0;
         p1_valid_q <= 1'b0;
         p1_chan_q  <= '0;
         p1_data_q  <= '0;
         m_valid_q  <= 1'b0;
         m_chan_q   <= '0;
         m_data_q   <= '0;
         rdy_q      <= 1'b0;
      end else begin
         sum_q      <= sum_d;
         wp_q       <= wp_d;
         fill_q     <= fill_d;
         primed_q   <= primed_d;
         p1_valid_q <= p1_valid_d;
         p1_chan_q  <= p1_chan_d;
         p1_data_q  <= p1_data_d;
         m_valid_q  <= m_valid_d;
         m_chan_q   <= m_chan_d;
         m_data_q   <= m_data_d;
         rdy_q      <= 1'b1;
      end
   end
endmodule

// File: tb/tb_boxcar_mc.sv
// tb_boxcar_mc: directed vector table plus hand sequences for stall, clear, reset and saturation
module tb_boxcar_mc;
   localparam int IW = 16, LGMEM = 6, LGCH = 2, OW = 22;
   logic             i_clk = 1'b0;
   logic             i_reset_n = 1'b1;
   logic             i_clear = 1'b0;
   logic [LGMEM-1:0] i_navg = '0;
   logic [3:0]       o_primed;
   int               checks = 0, errors = 0;
   boxcar_mc_if #(.CW(LGCH), .DW(IW)) s_if ();
   boxcar_mc_if #(.CW(LGCH), .DW(OW)) m_if ();
   boxcar_mc #(.IW(IW), .LGMEM(LGMEM), .LGCH(LGCH), .OW(OW)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clear(i_clear), .i_navg(i_navg),
      .s(s_if), .m(m_if), .o_primed(o_primed));
   always #5 i_clk = ~i_clk;
   typedef struct {
      logic clr; logic [5:0] navg; logic v; logic [1:0] ch; logic [15:0] d;
      logic ev; logic [1:0] ec; logic [21:0] ed; logic [3:0] ep;
   } vec_t;
   vec_t          vq[$];
   logic [IW-1:0] tx_q[$];
   logic [OW-1:0] rx_q[$];
   logic [OW-1:0] ex_q[$];
   function automatic vec_t mk(input int clr, navg, v, ch, d, ev, ec, ed, ep);
      vec_t r;
      r.clr = 1'(clr); r.navg = 6'(navg); r.v = 1'(v); r.ch = 2'(ch); r.d = 16'(d);
      r.ev = 1'(ev); r.ec = 2'(ec); r.ed = 22'(ed); r.ep = 4'(ep);
      return r;
   endfunction
   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask
   task automatic do_clear(input int navg);
      i_clear = 1'b1;
      i_navg = 6'(navg);
      @(posedge i_clk); #1;
      i_clear = 1'b0;
   endtask
   task automatic stream(input logic [1:0] ch, input int st_from, input int st_len, input int budget);
      int cyc = 0, drain = 0;
      logic acc, held = 1'b0;
      logic [OW-1:0] held_d = '0;
      while ((tx_q.size() > 0 || drain < 4) && cyc < budget) begin
         s_if.valid = tx_q.size() > 0;
         s_if.chan = ch;
         s_if.data = (tx_q.size() > 0) ? tx_q[0] : '0;
         m_if.ready = !(cyc >= st_from && cyc < st_from + st_len);
         #1;
         if (held) chk("held_data", 64'(m_if.data), 64'(held_d));
         if (m_if.valid && !m_if.ready) chk("stall_s_ready", 64'(s_if.ready), 0);
         held = m_if.valid && !m_if.ready;
         held_d = m_if.data;
         acc = s_if.valid && s_if.ready;
         if (m_if.valid && m_if.ready) begin
            chk("out_chan", 64'(m_if.chan), 64'(ch));
            rx_q.push_back(m_if.data);
         end
         @(posedge i_clk); #1;
         if (acc) void'(tx_q.pop_front());
         if (tx_q.size() == 0) drain++;
         cyc++;
      end
      s_if.valid = 1'b0;
      m_if.ready = 1'b1;
      if (tx_q.size() > 0) chk("stream_budget", 64'(tx_q.size()), 0);
   endtask
   task automatic compare_rx(input string nm);
      chk({nm, "_count"}, 64'(rx_q.size()), 64'(ex_q.size()));
      for (int i = 0; i < ex_q.size() && i < rx_q.size(); i++)
         chk($sformatf("%s_%0d", nm, i), 64'(rx_q[i]), 64'(ex_q[i]));
      rx_q.delete();
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      s_if.valid = 1'b0; s_if.chan = '0; s_if.data = '0; m_if.ready = 1'b1;
      #2 i_reset_n = 1'b0;
      #1;
      chk("rst_m_valid", 64'(m_if.valid), 0);
      chk("rst_m_data", 64'(m_if.data), 0);
      chk("rst_m_chan", 64'(m_if.chan), 0);
      chk("rst_primed", 64'(o_primed), 0);
      chk("rst_s_ready", 64'(s_if.ready), 0);
      repeat (2) @(posedge i_clk);
      #1 i_reset_n = 1'b1;
      chk("pre_edge_s_ready", 64'(s_if.ready), 0);
      @(posedge i_clk); #1;
      chk("post_edge_s_ready", 64'(s_if.ready), 1);
      // window 4 on ch0, then interleaved ch0/ch1 with window 2, window 0 acting as 1, clear discarding a beat
      vq.push_back(mk(1,4,0,0,0,   0,0,0,0));
      vq.push_back(mk(0,4,1,0,10,  0,0,0,0));
      vq.push_back(mk(0,4,1,0,20,  1,0,10,0));
      vq.push_back(mk(0,4,1,0,30,  1,0,30,0));
      vq.push_back(mk(0,4,1,0,40,  1,0,60,0));
      vq.push_back(mk(0,4,1,0,50,  1,0,100,1));
      vq.push_back(mk(0,4,0,0,0,   1,0,140,1));
      vq.push_back(mk(0,4,0,0,0,   0,0,0,1));
      vq.push_back(mk(1,2,0,0,0,   0,0,0,0));
      vq.push_back(mk(0,2,1,0,10,  0,0,0,0));
      vq.push_back(mk(0,2,1,1,1,   1,0,10,0));
      vq.push_back(mk(0,2,1,0,20,  1,1,1,0));
      vq.push_back(mk(0,2,1,1,2,   1,0,30,1));
      vq.push_back(mk(0,2,1,0,30,  1,1,3,3));
      vq.push_back(mk(0,2,1,1,3,   1,0,50,3));
      vq.push_back(mk(0,2,0,0,0,   1,1,5,3));
      vq.push_back(mk(0,2,0,0,0,   0,0,0,3));
      vq.push_back(mk(1,0,0,0,0,   0,0,0,0));
      vq.push_back(mk(0,0,1,2,7,   0,0,0,0));
      vq.push_back(mk(0,0,1,2,9,   1,2,7,4));
      vq.push_back(mk(0,0,0,0,0,   1,2,9,4));
      vq.push_back(mk(0,0,0,0,0,   0,0,0,4));
      vq.push_back(mk(1,0,1,3,100, 0,0,0,0));
      vq.push_back(mk(0,0,0,0,0,   0,0,0,0));
      vq.push_back(mk(0,0,0,0,0,   0,0,0,0));
      foreach (vq[i]) begin
         i_clear = vq[i].clr; i_navg = vq[i].navg;
         s_if.valid = vq[i].v; s_if.chan = vq[i].ch; s_if.data = vq[i].d;
         @(posedge i_clk); #1;
         chk($sformatf("vec%0d_valid", i), 64'(m_if.valid), 64'(vq[i].ev));
         if (vq[i].ev) begin
            chk($sformatf("vec%0d_chan", i), 64'(m_if.chan), 64'(vq[i].ec));
            chk($sformatf("vec%0d_data", i), 64'(m_if.data), 64'(vq[i].ed));
         end
         chk($sformatf("vec%0d_primed", i), 64'(o_primed), 64'(vq[i].ep));
      end
      i_clear = 1'b0; s_if.valid = 1'b0;
      // backpressure: 5 cycles of m_ready low mid-stream
      do_clear(2);
      tx_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
      ex_q = '{1, 3, 5, 7, 9, 11, 13, 15, 17, 19};
      stream(2'd2, 4, 5, 80);
      compare_rx("stall");
      // clear with window change while beats are in flight
      do_clear(4);
      s_if.valid = 1'b1; s_if.chan = 2'd0; s_if.data = 16'd5;
      @(posedge i_clk); #1;
      s_if.data = 16'd6;
      @(posedge i_clk); #1;
      i_clear = 1'b1; i_navg = 6'd8; s_if.data = 16'd7;
      @(posedge i_clk); #1;
      chk("clear_drop_valid", 64'(m_if.valid), 0);
      i_clear = 1'b0; s_if.valid = 1'b0;
      @(posedge i_clk); #1;
      chk("clear_no_stale", 64'(m_if.valid), 0);
      tx_q = '{25, 35, 45, 55};
      ex_q = '{25, 60, 105, 160};
      stream(2'd0, 100, 0, 40);
      compare_rx("clear");
      chk("clear_primed0", 64'(o_primed[0]), 0);
      // asynchronous reset with two beats in flight
      do_clear(2);
      s_if.valid = 1'b1; s_if.chan = 2'd1; s_if.data = 16'd7;
      @(posedge i_clk); #1;
      s_if.data = 16'd9;
      @(posedge i_clk); #1;
      i_reset_n = 1'b0;
      #1;
      chk("areset_m_valid", 64'(m_if.valid), 0);
      chk("areset_primed", 64'(o_primed), 0);
      chk("areset_s_ready", 64'(s_if.ready), 0);
      s_if.valid = 1'b0;
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      @(posedge i_clk); #1;
      chk("areset_no_stale", 64'(m_if.valid), 0);
      tx_q = '{4};
      ex_q = '{4};
      stream(2'd1, 100, 0, 20);
      compare_rx("areset");
      // full-scale samples with the longest window
      do_clear(63);
      for (int i = 0; i < 200; i++) tx_q.push_back(16'hFFFF);
      stream(2'd3, 1000, 0, 400);
      chk("sat_count", 64'(rx_q.size()), 200);
      if (rx_q.size() == 200) begin
         chk("sat_62", 64'(rx_q[61]), 64'd4063170);
         chk("sat_63", 64'(rx_q[62]), 64'd4128705);
         chk("sat_200", 64'(rx_q[199]), 64'd4128705);
      end
      chk("sat_primed3", 64'(o_primed[3]), 1);
      rx_q.delete();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/boxcar_mc.md
BOXCAR_MC -- requirements
Module: boxcar_mc

Interface
REQ-001 SHALL have parameter IW, default 16, unsigned input sample width.
REQ-002 SHALL have parameter LGMEM, default 6, log2 of per-channel history depth.
REQ-003 SHALL have parameter LGCH, default 2, log2 of channel count; NCH = 2^LGCH.
REQ-004 SHALL have parameter OW, default IW+LGMEM, output sum width.
REQ-005 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_clear  input  1  synchronous flush of all channel state.
REQ-008 SHALL have port i_navg  input  LGMEM  window length, common to all channels.
REQ-009 SHALL have port s_valid  input  1  input beat valid.
REQ-010 SHALL have port s_ready  output  1  input beat accepted when s_valid && s_ready.
REQ-011 SHALL have port s_chan  input  LGCH  channel index of input beat.
REQ-012 SHALL have port s_data  input  IW  input sample.
REQ-013 SHALL have port m_valid  output  1  output beat valid.
REQ-014 SHALL have port m_ready  input  1  downstream accepts when m_valid && m_ready.
REQ-015 SHALL have port m_chan  output  LGCH  channel index of output beat.
REQ-016 SHALL have port m_data  output  OW  windowed sum.
REQ-017 SHALL have port o_primed  output  NCH  bit c high once channel c has received >= navg samples since clear.

Function
REQ-018 SHALL keep per channel: 2^LGMEM-entry sample history, write pointer, running sum (OW bits), fill counter saturating at 2^LGMEM-1.
REQ-019 SHALL produce, per accepted beat on channel c, m_data = sum of the last N accepted samples of c (including current), N = max(i_navg,1).
REQ-020 SHALL update sum as sum + new - old, where old = sample written N beats earlier on c if fill counter >= N, else 0; history memory needs no reset.
REQ-021 SHALL present each result exactly 2 cycles after acceptance when not stalled; m_chan equals accepted s_chan; order preserved.
REQ-022 SHALL stall the whole pipeline while m_valid && !m_ready; s_ready = !(m_valid && !m_ready) && !i_clear.
REQ-023 SHALL hold m_data/m_chan stable while m_valid && !m_ready.
REQ-024 SHALL sustain one beat per cycle, including back-to-back beats on the same channel (sum forwarding, no bubbles).
REQ-025 SHALL never overflow: OW >= IW+LGMEM guarantees exact sums for navg <= 2^LGMEM-1.
REQ-026 i_clear SHALL, on the next edge, zero all sums, pointers, fill counters, o_primed, drop in-flight beats and deassert m_valid; a beat presented with i_clear is discarded.
REQ-027 i_navg SHALL only change with i_clear asserted in the same cycle; other changes give undefined sums but no lockup.

Reset
REQ-028 On i_reset_n low, asynchronously: m_valid=0, m_data=0, m_chan=0, o_primed=0, sums/pointers/fill counters=0, pipeline empty.
REQ-029 s_ready SHALL be 0 during reset and 1 on the first edge after release.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight beats; first post-reset result reflects only post-reset samples.

Configuration
REQ-031 Macro BOXCAR_MC_PRIME_EN: when defined, results for channel c are suppressed (state updated, m_valid not asserted) while o_primed[c]=0.
REQ-032 Without BOXCAR_MC_PRIME_EN, every accepted beat produces a result, including partial sums during fill.

Verification
REQ-033 navg=4, ch0 samples 10,20,30,40,50 back-to-back, m_ready=1 -> m_data 10,30,60,100,140 each 2 cycles after acceptance (PRIME_EN: only 100,140).
REQ-034 Interleave ch0 10,20,30 with ch1 1,2,3, navg=2 -> ch0 10,30,50; ch1 1,3,5; channels never mix.
REQ-035 m_ready low 5 cycles during stream -> s_ready low, m_data held, no beat lost or duplicated after release.
REQ-036 i_clear with navg 4->8 mid-stream, then ch0 25,35,45,55 -> 25,60,105,160; o_primed[0]=0.
REQ-037 i_reset_n pulsed low with 2 beats in flight -> m_valid=0 immediately, no stale output after release.
REQ-038 navg=63, 200 samples of 0xFFFF on ch3 -> steady sum 63*65535 = 4128705, no wrap.
